// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: constants and types shared by the PWM generator files.
//   DEF_RESOLUTION : default counter/duty width in bits (period = 2^width clk cycles)
//   DEF_DEADTIME   : default dead time in clk cycles for the complementary output
//   pwm_word_t     : counter/duty word at the default resolution
package pwm_gen_pkg;

  localparam int DEF_RESOLUTION = 8;
  localparam int DEF_DEADTIME   = 2;

  typedef logic [DEF_RESOLUTION-1:0] pwm_word_t;

endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: bundles the PWM generator's control and output signals.
//   duty    : requested high time per period (master -> slave)
//   enable  : run control (master -> slave)
//   pwm_out : PWM output (slave -> master)
//   pwm_n   : complementary output; driven only in builds that include it
// Modports: master (the controller driving duty/enable), slave (the generator).
interface pwm_gen_if #(
  parameter int RESOLUTION = pwm_gen_pkg::DEF_RESOLUTION
);

  logic [RESOLUTION-1:0] duty;
  logic                  enable;
  logic                  pwm_out;
  logic                  pwm_n;

  modport master (output duty, output enable, input pwm_out, input pwm_n);
  modport slave  (input duty, input enable, output pwm_out, output pwm_n);

endinterface

// File: rtl/pwm_gen_deadtime.sv
// pwm_gen_deadtime: registered complementary output with dead time.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   pwm_next  : value pwm_out takes on this edge
//   pwm_next2 : value pwm_out takes on the following edge
//   pwm_n     : complementary output; high only while pwm_out is low, after
//               pwm_out has been low for DEADTIME cycles, and dropping one
//               cycle before pwm_out rises
module pwm_gen_deadtime
  import pwm_gen_pkg::*;
#(
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_next,
  input  logic pwm_next2,
  output logic pwm_n
);

  localparam logic [7:0] DT = 8'(DEADTIME);

  // Length of the current low run of pwm_out, saturating so it never wraps
  // back below DT during a long low stretch.
  logic [7:0] low_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_run <= '0;
      pwm_n   <= 1'b0;
    end else begin
      pwm_n <= !pwm_next && !pwm_next2 && (low_run >= DT);
      if (pwm_next)
        low_run <= '0;
      else if (low_run != 8'hff)
        low_run <= low_run + 8'd1;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM generator with per-period duty latching.
//   duty    : requested high time in clk cycles per period
//   pwm_out : registered PWM output, lags the counter by one cycle
//   clk     : clock
//   enable  : run control; low holds the generator idle and re-arms duty
//   rst     : asynchronous active-high reset
//   pwm_n   : complementary output with dead time (PWM_GEN_COMPL_EN only)
// Build option: define PWM_GEN_COMPL_EN to compile in pwm_n and its dead-time
// counter; the default build has pwm_out only, with identical behaviour.
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int RESOLUTION = DEF_RESOLUTION,
  parameter int DEADTIME   = DEF_DEADTIME
) (
  input  logic [RESOLUTION-1:0] duty,
  output logic                  pwm_out,
  input  logic                  clk,
  input  logic                  enable,
  input  logic                  rst
`ifdef PWM_GEN_COMPL_EN
  ,
  output logic                  pwm_n
`endif
);

  localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

  logic [RESOLUTION-1:0] cnt;
  logic [RESOLUTION-1:0] duty_q;
  logic                  at_wrap;
  logic                  pwm_next;

  assign at_wrap  = (cnt == CNT_MAX);
  assign pwm_next = enable && (cnt < duty_q);

  // duty_q only moves at the period boundary (or while idle), so a duty
  // write mid-period can never shorten or stretch the pulse in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= pwm_next;
      if (enable)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (!enable || at_wrap)
        duty_q <= duty;
    end
  end

`ifdef PWM_GEN_COMPL_EN
  // One-edge lookahead of pwm_out so pwm_n can drop a cycle before pwm_out
  // rises. Enable is assumed to stay high; if it drops, pwm_out goes low
  // anyway and the prediction only errs on the safe side.
  logic [RESOLUTION-1:0] cnt_nxt;
  logic [RESOLUTION-1:0] duty_q_nxt;
  logic                  pwm_next2;

  assign cnt_nxt    = enable ? cnt + 1'b1 : '0;
  assign duty_q_nxt = (!enable || at_wrap) ? duty : duty_q;
  assign pwm_next2  = (cnt_nxt < duty_q_nxt);

  pwm_gen_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .pwm_next  (pwm_next),
    .pwm_next2 (pwm_next2),
    .pwm_n     (pwm_n)
  );
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed bench for pwm_gen (RESOLUTION=8, DEADTIME=2) with a
// period-level reference model compared on every negative clock edge.
module tb_pwm_gen;
  import pwm_gen_pkg::*;

  localparam int R  = 8;
  localparam int P  = 256;
  localparam int DT = 2;

  logic clk = 1'b0;
  logic rst;

  pwm_gen_if #(.RESOLUTION(R)) bus ();

  pwm_gen #(
    .RESOLUTION (R),
    .DEADTIME   (DT)
  ) dut (
    .duty    (bus.duty),
    .pwm_out (bus.pwm_out),
    .clk     (clk),
    .enable  (bus.enable),
    .rst     (rst)
`ifdef PWM_GEN_COMPL_EN
    ,
    .pwm_n   (bus.pwm_n)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: counts enabled edges since the last idle/reset and
  // derives the period phase from that count; each period uses the duty
  // captured when the previous period ended (or while idle).
  int m_run;
  int m_pduty;
  int m_low;
  bit m_out;
  bit m_n;

  always @(posedge clk or posedge rst) begin : model
    int k;
    bit nxt;
    bit nxt2;
    if (rst) begin
      m_run   = 0;
      m_pduty = 0;
      m_low   = 0;
      m_out   = 1'b0;
      m_n     = 1'b0;
    end else begin
      if (!bus.enable) begin
        nxt     = 1'b0;
        m_run   = 0;
        m_pduty = int'(bus.duty);
        nxt2    = (m_pduty > 0);
      end else begin
        k   = m_run % P;
        nxt = (k < m_pduty);
        if (k == P - 1) begin
          m_pduty = int'(bus.duty);
          nxt2    = (m_pduty > 0);
        end else begin
          nxt2 = ((k + 1) < m_pduty);
        end
        m_run++;
      end
      m_n   = !nxt && !nxt2 && (m_low >= DT);
      m_low = nxt ? 0 : ((m_low < 255) ? m_low + 1 : 255);
      m_out = nxt;
    end
  end

  always @(negedge clk) begin
    check("pwm_out_vs_model", int'(bus.pwm_out), int'(m_out));
`ifdef PWM_GEN_COMPL_EN
    check("pwm_n_vs_model", int'(bus.pwm_n), int'(m_n));
    check("no_overlap", int'(bus.pwm_n & bus.pwm_out), 0);
`endif
  end

  // Samples one full period starting at the next negedge; optionally
  // rewrites duty after sample index change_at.
  task automatic run_period(input int change_at, input int new_duty,
                            output int highs, output int first_low,
                            output int n_first, output int n_highs);
    highs     = 0;
    first_low = -1;
    n_first   = -1;
    n_highs   = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (bus.pwm_out)
        highs++;
      else if (first_low < 0)
        first_low = i;
`ifdef PWM_GEN_COMPL_EN
      if (bus.pwm_n) begin
        n_highs++;
        if (n_first < 0)
          n_first = i;
      end
`endif
      if (i == change_at)
        bus.duty = R'(new_duty);
    end
  endtask

  int hi, fl, nf, nh;

  initial begin
    rst        = 1'b0;
    bus.enable = 1'b0;
    bus.duty   = '0;
    #1 rst = 1'b1;
    #1 check("reset_pwm_out", int'(bus.pwm_out), 0);
    check("reset_cnt", int'(dut.cnt), 0);
`ifdef PWM_GEN_COMPL_EN
    check("reset_pwm_n", int'(bus.pwm_n), 0);
`endif
    bus.duty = 8'd64;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;

    for (int p = 0; p < 3; p++) begin
      run_period(-1, 0, hi, fl, nf, nh);
      check("duty64_highs", hi, 64);
      check("duty64_phase", fl, 64);
`ifdef PWM_GEN_COMPL_EN
      check("dead_n_rise_idx", nf, 66);
      check("dead_n_highs", nh, 189);
`endif
    end

    bus.duty = 8'd0;
    run_period(-1, 0, hi, fl, nf, nh);
    check("duty0_pending_highs", hi, 64);
    run_period(-1, 0, hi, fl, nf, nh);
    check("duty0_highs", hi, 0);
    bus.duty = 8'd255;
    run_period(-1, 0, hi, fl, nf, nh);
    check("duty255_pending_highs", hi, 0);
    run_period(-1, 0, hi, fl, nf, nh);
    check("duty255_highs", hi, 255);
    check("duty255_low_slot", fl, 255);

    bus.duty = 8'd64;
    run_period(-1, 0, hi, fl, nf, nh);
    check("duty64_pending_highs", hi, 255);
    run_period(10, 128, hi, fl, nf, nh);
    check("midperiod_change_keeps", hi, 64);
    run_period(-1, 0, hi, fl, nf, nh);
    check("midperiod_change_next", hi, 128);

    bus.duty = 8'd100;
    run_period(-1, 0, hi, fl, nf, nh);
    check("duty100_pending_highs", hi, 128);
    repeat (31) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("disable_pwm_out", int'(bus.pwm_out), 0);
    check("disable_cnt", int'(dut.cnt), 0);
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    run_period(-1, 0, hi, fl, nf, nh);
    check("reenable_highs", hi, 100);
    check("reenable_phase", fl, 100);

    repeat (20) @(negedge clk);
    check("pre_reset_high", int'(bus.pwm_out), 1);
    #2 rst = 1'b1;
    #1 check("async_reset_pwm_out", int'(bus.pwm_out), 0);
    @(negedge clk);
    rst = 1'b0;
    run_period(-1, 0, hi, fl, nf, nh);
    check("post_reset_first_highs", hi, 0);
    run_period(-1, 0, hi, fl, nf, nh);
    check("post_reset_highs", hi, 100);
    check("post_reset_phase", fl, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
